// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue-side sequencer for the combinational ALU (operand hold, result capture, write-back handshake).
// Optional compare flags (flag_c/flag_s/flag_z) are built only when P32_ALU_FLAGS_EN is defined.
`ifndef ALU_OPCODE
`define ALU_OPCODE [3:0]
`endif
`ifndef WORD
`define WORD [31:0]
`endif

module alu_issue_ctrl #(
    parameter int LONG_LAT = 4,
    parameter int RD_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic `ALU_OPCODE issue_com,
    input  logic `WORD       issue_a,
    input  logic `WORD       issue_b,
    input  logic [RD_W-1:0]  issue_rd,
    output logic `ALU_OPCODE alu_com,
    output logic `WORD       alu_in0,
    output logic `WORD       alu_in1,
    input  logic `WORD       alu_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic `WORD       wb_data,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_we,
    output logic             err_div0,
`ifdef P32_ALU_FLAGS_EN
    output logic             flag_c,
    output logic             flag_s,
    output logic             flag_z,
    output logic             err_op
`else
    output logic             err_op
`endif
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CGE = 4'd11;
    localparam logic [3:0] OP_CGT = 4'd12;

    localparam int CNT_W = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_div(input logic [3:0] c);
        return (c == OP_DIV) || (c == OP_MOD);
    endfunction

    function automatic logic is_long(input logic [3:0] c);
        return (c == OP_MUL) || is_div(c);
    endfunction

    function automatic logic is_shift(input logic [3:0] c);
        return (c == OP_SHL) || (c == OP_SHR);
    endfunction

    function automatic logic is_cmp(input logic [3:0] c);
        return (c == OP_CMP) || (c == OP_CGE) || (c == OP_CGT);
    endfunction

    function automatic logic is_known(input logic [3:0] c);
        return (c <= OP_CGT);
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        com_q, com_d;
    logic [31:0]       in0_q, in0_d;
    logic [31:0]       in1_q, in1_d;
    logic [31:0]       data_q, data_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              we_q, we_d;
    logic              div0_q, div0_d;
    logic              eop_q, eop_d;
    logic              accept;
    logic              capture;
    logic              b_zero;

    assign issue_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && wb_ready));
    assign accept      = issue_valid && issue_ready;
    assign capture     = (state_q == S_EXEC) && (cnt_q == '0);
    assign b_zero      = (issue_b == 32'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        com_d   = com_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        data_d  = data_q;
        rd_d    = rd_q;
        we_d    = we_q;
        div0_d  = div0_q;
        eop_d   = eop_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (wb_ready) begin
                    state_d = accept ? S_EXEC : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Result selection: ALU output is only trusted for ops that write the register file.
        if (capture) begin
            data_d = '0;
            we_d   = 1'b0;
            div0_d = 1'b0;
            eop_d  = 1'b0;
            if (!is_known(com_q)) begin
                eop_d = 1'b1;
            end else if (is_cmp(com_q)) begin
                data_d = '0;
            end else if (is_div(com_q) && (in1_q == 32'd0)) begin
                data_d = (com_q == OP_DIV) ? 32'hFFFF_FFFF : in0_q;
                div0_d = 1'b1;
            end else begin
                data_d = alu_out;
                we_d   = 1'b1;
            end
        end

        if (accept) begin
            com_d = issue_com;
            in0_d = issue_a;
            in1_d = is_shift(issue_com) ? {27'b0, issue_b[4:0]} : issue_b;
            rd_d  = issue_rd;
            // Divide by zero never waits on the ALU, so it takes the short path.
            cnt_d = (is_long(issue_com) && !(is_div(issue_com) && b_zero))
                    ? CNT_W'(LONG_LAT - 1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            com_q   <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            div0_q  <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            com_q   <= com_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            div0_q  <= div0_d;
            eop_q   <= eop_d;
        end
    end

    assign alu_com  = com_q;
    assign alu_in0  = in0_q;
    assign alu_in1  = in1_q;
    assign wb_valid = (state_q == S_DONE);
    assign wb_data  = data_q;
    assign wb_rd    = rd_q;
    assign wb_we    = we_q;
    assign err_div0 = div0_q;
    assign err_op   = eop_q;

`ifdef P32_ALU_FLAGS_EN
    // Flags packed as {c, s, z}; unsigned compare of the held operands.
    function automatic logic [2:0] cmp_flags(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [2:0] f;
        f = 3'b000;
        case (c)
            OP_CMP:  f = (a == b) ? 3'b001 : 3'b000;
            OP_CGE:  f = (a >= b) ? 3'b101 : 3'b010;
            OP_CGT:  f = (a > b)  ? 3'b100 : 3'b011;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

    logic [2:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (capture && is_cmp(com_q)) begin
            flags_d = cmp_flags(com_q, in0_q, in1_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flag_c = flags_q[2];
    assign flag_s = flags_q[1];
    assign flag_z = flags_q[0];
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed literal cases plus randomized traffic against a transaction-level model.
module tb_alu_issue_ctrl;

    localparam int LONG_LAT = 4;
    localparam int RD_W     = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CGE = 4'd11;
    localparam logic [3:0] OP_CGT = 4'd12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [3:0]      issue_com = '0;
    logic [31:0]     issue_a = '0;
    logic [31:0]     issue_b = '0;
    logic [RD_W-1:0] issue_rd = '0;
    logic [3:0]      alu_com;
    logic [31:0]     alu_in0;
    logic [31:0]     alu_in1;
    logic [31:0]     alu_out;
    logic            wb_valid;
    logic            wb_ready = 1'b1;
    logic [31:0]     wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_we;
    logic            err_div0;
    logic            err_op;
`ifdef P32_ALU_FLAGS_EN
    logic            flag_c, flag_s, flag_z;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(.LONG_LAT(LONG_LAT), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_com(issue_com), .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .alu_com(alu_com), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_we(wb_we), .err_div0(err_div0),
`ifdef P32_ALU_FLAGS_EN
        .flag_c(flag_c), .flag_s(flag_s), .flag_z(flag_z),
`endif
        .err_op(err_op)
    );

    // Combinational ALU stand-in; junk values on non-writing ops expose misuse of alu_out.
    always_comb begin
        case (alu_com)
            OP_ADD:  alu_out = alu_in0 + alu_in1;
            OP_SUB:  alu_out = alu_in0 - alu_in1;
            OP_MUL:  alu_out = alu_in0 * alu_in1;
            OP_DIV:  alu_out = (alu_in1 == 0) ? 32'hDEAD_BEEF : alu_in0 / alu_in1;
            OP_MOD:  alu_out = (alu_in1 == 0) ? 32'hDEAD_BEEF : alu_in0 % alu_in1;
            OP_AND:  alu_out = alu_in0 & alu_in1;
            OP_OR:   alu_out = alu_in0 | alu_in1;
            OP_XOR:  alu_out = alu_in0 ^ alu_in1;
            OP_SHL:  alu_out = alu_in0 << alu_in1;
            OP_SHR:  alu_out = alu_in0 >> alu_in1;
            default: alu_out = 32'h5A5A_0000 | {28'b0, alu_com};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic        div0;
        logic        eop;
        logic        cmp;
        logic [2:0]  fl;
    } res_t;

    function automatic res_t spec_result(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
        res_t r;
        r = '0;
        r.we = 1'b1;
        case (c)
            OP_ADD: r.data = a + b;
            OP_SUB: r.data = a - b;
            OP_MUL: r.data = a * b;
            OP_DIV: if (b == 0) begin r.data = 32'hFFFF_FFFF; r.div0 = 1; r.we = 0; end
                    else r.data = a / b;
            OP_MOD: if (b == 0) begin r.data = a; r.div0 = 1; r.we = 0; end
                    else r.data = a % b;
            OP_AND: r.data = a & b;
            OP_OR:  r.data = a | b;
            OP_XOR: r.data = a ^ b;
            OP_SHL: r.data = a << b[4:0];
            OP_SHR: r.data = a >> b[4:0];
            OP_CMP: begin r.we = 0; r.cmp = 1; r.fl = (a == b) ? 3'b001 : 3'b000; end
            OP_CGE: begin r.we = 0; r.cmp = 1; r.fl = (a >= b) ? 3'b101 : 3'b010; end
            OP_CGT: begin r.we = 0; r.cmp = 1; r.fl = (a > b)  ? 3'b100 : 3'b011; end
            default: begin r.we = 0; r.eop = 1; end
        endcase
        return r;
    endfunction

    // Transaction model: one op in flight, result visible from its ready cycle until consumed.
    bit              m_busy = 0;
    int              m_rdy  = 0;
    logic [3:0]      m_com  = '0;
    logic [31:0]     m_a    = '0;
    logic [31:0]     m_b1   = '0;
    logic [RD_W-1:0] m_rd   = '0;
    res_t            m_res  = '0;
    logic [2:0]      m_fl   = '0;

    always @(negedge clk) begin : model_cmp
        bit ewv, eir, lng;
        ewv = m_busy && (cyc >= m_rdy);
        eir = !rst && (!m_busy || (ewv && wb_ready));
        chk("issue_ready", 32'(issue_ready), 32'(eir));
        chk("wb_valid", 32'(wb_valid), 32'(ewv));
        chk("alu_com", 32'(alu_com), 32'(m_com));
        chk("alu_in0", alu_in0, m_a);
        chk("alu_in1", alu_in1, m_b1);
        if (ewv) begin
            chk("wb_data", wb_data, m_res.data);
            chk("wb_rd", 32'(wb_rd), 32'(m_rd));
            chk("wb_we", 32'(wb_we), 32'(m_res.we));
            chk("err_div0", 32'(err_div0), 32'(m_res.div0));
            chk("err_op", 32'(err_op), 32'(m_res.eop));
        end
`ifdef P32_ALU_FLAGS_EN
        chk("flags", 32'({flag_c, flag_s, flag_z}), 32'((ewv && m_res.cmp) ? m_res.fl : m_fl));
`endif
        if (rst) begin
            m_busy = 0; m_com = '0; m_a = '0; m_b1 = '0; m_rd = '0; m_fl = '0;
        end else begin
            if (ewv && wb_ready) begin
                m_busy = 0;
                if (m_res.cmp) m_fl = m_res.fl;
            end
            if (issue_valid && eir) begin
                m_busy = 1;
                m_com  = issue_com;
                m_a    = issue_a;
                m_b1   = (issue_com == OP_SHL || issue_com == OP_SHR) ? {27'b0, issue_b[4:0]} : issue_b;
                m_rd   = issue_rd;
                m_res  = spec_result(issue_com, issue_a, issue_b);
                lng    = (issue_com == OP_MUL || issue_com == OP_DIV || issue_com == OP_MOD) && !m_res.div0;
                m_rdy  = cyc + 1 + (lng ? LONG_LAT : 1);
            end
        end
    end

    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd, input logic [31:0] ed, input logic ewe,
                         input logic ed0, input logic eeo, input int elat,
                         input logic [31:0] ein1, input int hold, input string nm);
        int acc;
        bit seen;
        @(posedge clk); #1;
        issue_valid = 1; issue_com = c; issue_a = a; issue_b = b; issue_rd = rd;
        wb_ready = (hold == 0);
        acc = cyc;
        @(negedge clk);
        chk({nm, " accept"}, 32'(issue_ready), 32'd1);
        @(posedge clk); #1;
        issue_valid = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wb_valid) seen = 1;
            else begin
                chk({nm, " in0 held"}, alu_in0, a);
                chk({nm, " in1 held"}, alu_in1, ein1);
            end
        end
        chk({nm, " latency"}, seen ? 32'(cyc - acc) : 32'hFFFF_FFFF, 32'(elat));
        chk({nm, " data"}, wb_data, ed);
        chk({nm, " rd"}, 32'(wb_rd), 32'(rd));
        chk({nm, " we"}, 32'(wb_we), 32'(ewe));
        chk({nm, " div0"}, 32'(err_div0), 32'(ed0));
        chk({nm, " err_op"}, 32'(err_op), 32'(eeo));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            issue_valid = 1; issue_com = OP_ADD; issue_a = 32'h11; issue_b = 32'h22; issue_rd = 5'd30;
            @(negedge clk);
            chk({nm, " hold valid"}, 32'(wb_valid), 32'd1);
            chk({nm, " hold data"}, wb_data, ed);
            chk({nm, " hold rd"}, 32'(wb_rd), 32'(rd));
            chk({nm, " hold ready"}, 32'(issue_ready), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            issue_valid = 0; wb_ready = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset issue_ready", 32'(issue_ready), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post-reset issue_ready", 32'(issue_ready), 32'd1);
        chk("post-reset wb_valid", 32'(wb_valid), 32'd0);
        chk("post-reset wb_data", wb_data, 32'd0);
        chk("post-reset wb_we", 32'(wb_we), 32'd0);
        chk("post-reset errs", 32'({err_div0, err_op}), 32'd0);
        chk("post-reset alu_in0", alu_in0, 32'd0);

        do_op(OP_ADD, 32'd5, 32'd7, 5'd3, 32'd12, 1, 0, 0, 2, 32'd7, 0, "add");
        do_op(OP_MUL, 32'd6, 32'd7, 5'd4, 32'd42, 1, 0, 0, LONG_LAT + 1, 32'd7, 0, "mul");
        do_op(OP_DIV, 32'd9, 32'd0, 5'd5, 32'hFFFF_FFFF, 0, 1, 0, 2, 32'd0, 0, "div0");
        do_op(OP_MOD, 32'd9, 32'd0, 5'd6, 32'd9, 0, 1, 0, 2, 32'd0, 0, "mod0");
        do_op(OP_DIV, 32'd100, 32'd7, 5'd8, 32'd14, 1, 0, 0, LONG_LAT + 1, 32'd7, 0, "div");
        do_op(OP_SHL, 32'd1, 32'd33, 5'd7, 32'd2, 1, 0, 0, 2, 32'd1, 3, "shl");
        do_op(OP_CGT, 32'd3, 32'd3, 5'd9, 32'd0, 0, 0, 0, 2, 32'd3, 0, "cgt");
`ifdef P32_ALU_FLAGS_EN
        chk("cgt flags", 32'({flag_c, flag_s, flag_z}), 32'b011);
`endif
        do_op(4'd15, 32'd1, 32'd2, 5'd10, 32'd0, 0, 0, 1, 2, 32'd2, 0, "badop");

        // Back-to-back: XOR is taken in the cycle SUB's result is consumed.
        @(posedge clk); #1;
        issue_valid = 1; issue_com = OP_SUB; issue_a = 32'd10; issue_b = 32'd3; issue_rd = 5'd1;
        wb_ready = 1;
        @(posedge clk); #1;
        issue_com = OP_XOR; issue_a = 32'hF0; issue_b = 32'h0F; issue_rd = 5'd2;
        @(negedge clk);
        chk("b2b exec ready", 32'(issue_ready), 32'd0);
        @(negedge clk);
        chk("b2b sub valid", 32'(wb_valid), 32'd1);
        chk("b2b sub data", wb_data, 32'd7);
        chk("b2b sub rd", 32'(wb_rd), 32'd1);
        chk("b2b done ready", 32'(issue_ready), 32'd1);
        @(posedge clk); #1;
        issue_valid = 0;
        @(negedge clk);
        chk("b2b bubble", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("b2b xor valid", 32'(wb_valid), 32'd1);
        chk("b2b xor data", wb_data, 32'hFF);
        chk("b2b xor rd", 32'(wb_rd), 32'd2);

        // Reset while a long DIV is executing drops it.
        @(posedge clk); #1;
        issue_valid = 1; issue_com = OP_DIV; issue_a = 32'd100; issue_b = 32'd7; issue_rd = 5'd4;
        @(posedge clk); #1;
        issue_valid = 0;
        rst = 1;
        @(negedge clk);
        chk("rst exec ready", 32'(issue_ready), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst dropped wb_valid", 32'(wb_valid), 32'd0);
        end
        chk("rst alu_in0", alu_in0, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst         = ($urandom_range(0, 199) == 0);
            wb_ready    = ($urandom_range(0, 3) != 0);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_com   = 4'($urandom_range(0, 15));
            issue_a     = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20));
            case ($urandom_range(0, 3))
                0:       issue_b = 32'd0;
                1:       issue_b = 32'($urandom_range(0, 40));
                2:       issue_b = issue_a;
                default: issue_b = $urandom;
            endcase
            issue_rd    = 5'($urandom_range(0, 31));
        end
        @(posedge clk); #1;
        rst = 0; issue_valid = 0; wb_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
